display_scan_driver: RTL and testbench

- Downstream consumer of the frequency counter's BCD result (ten_count, unit_count, load).
- Latches each result and time-multiplexes it onto a two-digit common-cathode/anode 7-segment PMOD.
- Inserts blanking gaps between digits to suppress ghosting.
- Applies leading-zero blanking, out-of-range marking and output polarity.

---
 rtl/disp_pkg.sv | 18 +
 rtl/seg_decoder.sv | 15 +
 rtl/display_scan_driver.sv | 82 ++++++++
 tb/tb_display_scan_driver.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// disp_pkg: scan FSM states and 7-segment patterns shared by the display driver
package disp_pkg;
  typedef enum logic [1:0] {S_TENS, S_GAP1, S_UNITS, S_GAP2} state_t;
  localparam logic [6:0] SEG_OFF  = 7'h00;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [9:0][6:0] SEG_DIGITS = {SEG_9, SEG_8, SEG_7, SEG_6, SEG_5,
                                            SEG_4, SEG_3, SEG_2, SEG_1, SEG_0};
endpackage

// File: rtl/seg_decoder.sv
// seg_decoder: BCD value to {g..a} pattern with blanking, dash for 10..15 and optional inversion
module seg_decoder
  import disp_pkg::*;
(
  input  logic [3:0] value,
  input  logic       blank,
  input  logic       invert,
  output logic [6:0] seg
);
  logic [6:0] raw;
  always_comb begin
    raw = blank ? SEG_OFF : value > 4'd9 ? SEG_DASH : SEG_DIGITS[value];
    seg = raw ^ {7{invert}};
  end
endmodule

// File: rtl/display_scan_driver.sv
// display_scan_driver: latches BCD results and multiplexes them onto a two-digit 7-segment display
module display_scan_driver
  import disp_pkg::*;
#(
  parameter int unsigned REFRESH_CYCLES = 4000,
  parameter int unsigned BLANK_CYCLES   = 100,
  parameter bit          INVERT         = 1'b1,
  parameter bit          LZ_BLANK       = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] ten_count,
  input  logic [3:0] unit_count,
  output logic [6:0] segments,
  output logic       digit,
  output logic       frame_done
);
  localparam int unsigned MAXC = REFRESH_CYCLES > BLANK_CYCLES ? REFRESH_CYCLES : BLANK_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] R_LAST = CW'(REFRESH_CYCLES - 1);
  localparam logic [CW-1:0] B_LAST = CW'(BLANK_CYCLES - 1);
  localparam bit GAPS = BLANK_CYCLES != 0;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0] sh_tens_q, sh_tens_d, sh_units_q, sh_units_d;
  logic [3:0] act_tens_q, act_tens_d, act_units_q, act_units_d;
  logic [6:0] segments_q, segments_d, seg_pat;
  logic digit_q, digit_d, frame_done_q, frame_done_d;
  logic in_gap, show_tens, last, wrap;
  seg_decoder u_dec (
    .value (show_tens ? act_tens_q : act_units_q),
    .blank (in_gap || (show_tens && LZ_BLANK && act_tens_q == 4'd0)),
    .invert(INVERT),
    .seg   (seg_pat)
  );
  always_comb begin
    in_gap       = state_q == S_GAP1 || state_q == S_GAP2;
    show_tens    = state_q == S_TENS;
    last         = cnt_q == (in_gap ? B_LAST : R_LAST);
    state_d      = !last ? state_q :
                   state_q == S_TENS  ? (GAPS ? S_GAP1 : S_UNITS) :
                   state_q == S_GAP1  ? S_UNITS :
                   state_q == S_UNITS ? (GAPS ? S_GAP2 : S_TENS) : S_TENS;
    wrap         = last && state_d == S_TENS;
    cnt_d        = last ? '0 : cnt_q + 1'b1;
    sh_tens_d    = load ? ten_count : sh_tens_q;
    sh_units_d   = load ? unit_count : sh_units_q;
    // active copy takes the shadow as it stood before this edge, so a boundary load waits a frame
    act_tens_d   = wrap ? sh_tens_q : act_tens_q;
    act_units_d  = wrap ? sh_units_q : act_units_q;
    segments_d   = seg_pat;
    digit_d      = show_tens ? 1'b1 : state_q == S_UNITS ? 1'b0 : digit_q;
    frame_done_d = wrap;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_TENS;
      cnt_q        <= '0;
      sh_tens_q    <= '0;
      sh_units_q   <= '0;
      act_tens_q   <= '0;
      act_units_q  <= '0;
      segments_q   <= SEG_OFF ^ {7{INVERT}};
      digit_q      <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sh_tens_q    <= sh_tens_d;
      sh_units_q   <= sh_units_d;
      act_tens_q   <= act_tens_d;
      act_units_q  <= act_units_d;
      segments_q   <= segments_d;
      digit_q      <= digit_d;
      frame_done_q <= frame_done_d;
    end
  end
  assign segments   = segments_q;
  assign digit      = digit_q;
  assign frame_done = frame_done_q;
endmodule

// File: tb/tb_display_scan_driver.sv
// tb_display_scan_driver: randomized and directed checks of two driver configurations against a frame-position model
module tb_display_scan_driver;
  localparam int R  = 4;
  localparam int BA = 1;
  localparam int BB = 0;
  localparam int LA = 2 * (R + BA);
  localparam int LB = 2 * (R + BB);
  logic clk = 1'b0, reset = 1'b1, load = 1'b0;
  logic [3:0] ten_count = '0, unit_count = '0;
  logic [6:0] a_seg, b_seg;
  logic a_dig, b_dig, a_fd, b_fd;
  int checks = 0, errors = 0, m_t = 0;
  logic [7:0] sh = '0, ac_a = '0, ac_b = '0;
  logic [8:0] exp_a = 9'h080, exp_b = 9'h0FF;

  always #5 clk = ~clk;

  display_scan_driver #(.REFRESH_CYCLES(R), .BLANK_CYCLES(BA), .INVERT(1'b0), .LZ_BLANK(1'b1)) dut_a (
    .clk(clk), .reset(reset), .load(load), .ten_count(ten_count), .unit_count(unit_count),
    .segments(a_seg), .digit(a_dig), .frame_done(a_fd));
  display_scan_driver #(.REFRESH_CYCLES(R), .BLANK_CYCLES(BB), .INVERT(1'b1), .LZ_BLANK(1'b1)) dut_b (
    .clk(clk), .reset(reset), .load(load), .ten_count(ten_count), .unit_count(unit_count),
    .segments(b_seg), .digit(b_dig), .frame_done(b_fd));

  function automatic logic [6:0] pat(input logic [3:0] v);
    case (v)
      4'd0: return 7'h3F; 4'd1: return 7'h06; 4'd2: return 7'h5B; 4'd3: return 7'h4F;
      4'd4: return 7'h66; 4'd5: return 7'h6D; 4'd6: return 7'h7D; 4'd7: return 7'h07;
      4'd8: return 7'h7F; 4'd9: return 7'h6F; default: return 7'h40;
    endcase
  endfunction

  // expected {frame_done, digit, segments} registered from frame position p
  function automatic logic [8:0] model_out(input int p, input logic [7:0] ac, input int r, input int b, input bit inv);
    logic [6:0] s;
    logic d;
    if (p < r) begin s = (ac[7:4] == 4'd0) ? 7'h00 : pat(ac[7:4]); d = 1'b1; end
    else if (p < r + b) begin s = 7'h00; d = 1'b1; end
    else if (p < 2 * r + b) begin s = pat(ac[3:0]); d = 1'b0; end
    else begin s = 7'h00; d = 1'b0; end
    return {p == 2 * (r + b) - 1, d, inv ? ~s : s};
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_t <= 0; sh <= '0; ac_a <= '0; ac_b <= '0;
      exp_a <= 9'h080; exp_b <= 9'h0FF;
    end else begin
      exp_a <= model_out(m_t % LA, ac_a, R, BA, 1'b0);
      exp_b <= model_out(m_t % LB, ac_b, R, BB, 1'b1);
      if (m_t % LA == LA - 1) ac_a <= sh;
      if (m_t % LB == LB - 1) ac_b <= sh;
      if (load) sh <= {ten_count, unit_count};
      m_t <= m_t + 1;
    end
  end

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks += 2;
      if ({a_fd, a_dig, a_seg} !== 9'h080) begin errors++; $display("FAIL reset_a got %h exp 080", {a_fd, a_dig, a_seg}); end
      if ({b_fd, b_dig, b_seg} !== 9'h0FF) begin errors++; $display("FAIL reset_b got %h exp 0ff", {b_fd, b_dig, b_seg}); end
    end
    reset = 1'b0;
  endtask

  task automatic test_basic;
    logic [8:0] ef;
    int fd_cnt = 0;
    ten_count = 4'd2; unit_count = 4'd3; load = 1'b1;
    for (int i = 0; i < LA + 2; i++) begin
      @(negedge clk);
      load = 1'b0;
      checks += 2;
      if ({a_fd, a_dig, a_seg} !== exp_a) begin errors++; $display("FAIL basic_a t=%0d got %h exp %h", m_t, {a_fd, a_dig, a_seg}, exp_a); end
      if ({b_fd, b_dig, b_seg} !== exp_b) begin errors++; $display("FAIL basic_b t=%0d got %h exp %h", m_t, {b_fd, b_dig, b_seg}, exp_b); end
    end
    for (int k = 0; k < LA && m_t % LA != 1; k++) @(negedge clk);
    checks++;
    if (m_t % LA != 1) begin errors++; $display("FAIL basic_align got %0d exp 1", m_t % LA); end
    for (int i = 0; i < LA; i++) begin
      ef = i < 4 ? 9'h05B : i == 4 ? 9'h000 : i < 9 ? 9'h04F : 9'h100;
      if (i <= 4) ef[7] = 1'b1;
      checks++;
      if ({a_fd, a_dig, a_seg} !== ef) begin errors++; $display("FAIL basic_frame i=%0d got %h exp %h", i, {a_fd, a_dig, a_seg}, ef); end
      fd_cnt += int'(a_fd);
      @(negedge clk);
    end
    checks++;
    if (fd_cnt != 1) begin errors++; $display("FAIL basic_fd_count got %0d exp 1", fd_cnt); end
  endtask

  task automatic test_deferred;
    int tb;
    for (int k = 0; k < LA && m_t % LA != 4; k++) @(negedge clk);
    ten_count = 4'd8; unit_count = 4'd8; load = 1'b1;
    for (int i = 0; i < 2 * LA; i++) begin
      @(negedge clk);
      load = 1'b0;
      checks += 2;
      if ({a_fd, a_dig, a_seg} !== exp_a) begin errors++; $display("FAIL defer_a t=%0d got %h exp %h", m_t, {a_fd, a_dig, a_seg}, exp_a); end
      if ({b_fd, b_dig, b_seg} !== exp_b) begin errors++; $display("FAIL defer_b t=%0d got %h exp %h", m_t, {b_fd, b_dig, b_seg}, exp_b); end
    end
    for (int k = 0; k < LA && m_t % LA != LA - 1; k++) @(negedge clk);
    tb = m_t;
    ten_count = 4'd5; unit_count = 4'd6; load = 1'b1;
    for (int i = 0; i < 2 * LA + 2; i++) begin
      @(negedge clk);
      load = 1'b0;
      checks += 2;
      if ({a_fd, a_dig, a_seg} !== exp_a) begin errors++; $display("FAIL boundary_a t=%0d got %h exp %h", m_t, {a_fd, a_dig, a_seg}, exp_a); end
      if ({b_fd, b_dig, b_seg} !== exp_b) begin errors++; $display("FAIL boundary_b t=%0d got %h exp %h", m_t, {b_fd, b_dig, b_seg}, exp_b); end
      if (m_t == tb + 2) begin
        checks++;
        if (a_seg !== 7'h7F) begin errors++; $display("FAIL boundary_old got %h exp 7f", a_seg); end
      end
      if (m_t == tb + 2 + LA) begin
        checks++;
        if (a_seg !== 7'h6D) begin errors++; $display("FAIL boundary_new got %h exp 6d", a_seg); end
      end
    end
  endtask

  task automatic test_lz_range;
    for (int n = 0; n < 2; n++) begin
      ten_count = n == 0 ? 4'd0 : 4'd12;
      unit_count = n == 0 ? 4'd7 : 4'd15;
      load = 1'b1;
      for (int i = 0; i < 2 * LA + 2; i++) begin
        @(negedge clk);
        load = 1'b0;
        checks += 2;
        if ({a_fd, a_dig, a_seg} !== exp_a) begin errors++; $display("FAIL lz_range_a t=%0d got %h exp %h", m_t, {a_fd, a_dig, a_seg}, exp_a); end
        if ({b_fd, b_dig, b_seg} !== exp_b) begin errors++; $display("FAIL lz_range_b t=%0d got %h exp %h", m_t, {b_fd, b_dig, b_seg}, exp_b); end
      end
    end
  endtask

  task automatic test_gapless;
    int offs = 0;
    ten_count = 4'd1; unit_count = 4'd9; load = 1'b1;
    for (int i = 0; i < 3 * LB; i++) begin
      @(negedge clk);
      load = 1'b0;
      checks++;
      if ({b_fd, b_dig, b_seg} !== exp_b) begin errors++; $display("FAIL gapless_b t=%0d got %h exp %h", m_t, {b_fd, b_dig, b_seg}, exp_b); end
      if (i >= LB + 2) begin
        offs += int'(b_seg == 7'h7F);
        if (m_t % LB == 1) begin
          checks++;
          if (b_seg !== 7'h79) begin errors++; $display("FAIL gapless_tens got %h exp 79", b_seg); end
        end
        if (m_t % LB == 1 + R) begin
          checks++;
          if (b_seg !== 7'h10) begin errors++; $display("FAIL gapless_units got %h exp 10", b_seg); end
        end
      end
    end
    checks++;
    if (offs != 0) begin errors++; $display("FAIL gapless_off_cycles got %0d exp 0", offs); end
  endtask

  task automatic test_reset_mid;
    for (int k = 0; k < LA && m_t % LA != R + BA + 1; k++) @(negedge clk);
    reset = 1'b1; load = 1'b1; ten_count = 4'd5; unit_count = 4'd5;
    @(negedge clk);
    checks += 2;
    if ({a_fd, a_dig, a_seg} !== 9'h080) begin errors++; $display("FAIL midreset_a got %h exp 080", {a_fd, a_dig, a_seg}); end
    if ({b_fd, b_dig, b_seg} !== 9'h0FF) begin errors++; $display("FAIL midreset_b got %h exp 0ff", {b_fd, b_dig, b_seg}); end
    reset = 1'b0; load = 1'b0;
    for (int i = 0; i < 2 * LA + 2; i++) begin
      @(negedge clk);
      checks += 2;
      if ({a_fd, a_dig, a_seg} !== exp_a) begin errors++; $display("FAIL midreset_run_a t=%0d got %h exp %h", m_t, {a_fd, a_dig, a_seg}, exp_a); end
      if ({b_fd, b_dig, b_seg} !== exp_b) begin errors++; $display("FAIL midreset_run_b t=%0d got %h exp %h", m_t, {b_fd, b_dig, b_seg}, exp_b); end
      if (m_t == LA + 1 + R + BA) begin
        checks++;
        if ({a_dig, a_seg} !== 8'h3F) begin errors++; $display("FAIL midreset_units got %h exp 3f", {a_dig, a_seg}); end
      end
      if (m_t == LA + 1) begin
        checks++;
        if ({a_dig, a_seg} !== 8'h80) begin errors++; $display("FAIL midreset_tens got %h exp 80", {a_dig, a_seg}); end
      end
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      checks += 2;
      if ({a_fd, a_dig, a_seg} !== exp_a) begin errors++; $display("FAIL random_a t=%0d got %h exp %h", m_t, {a_fd, a_dig, a_seg}, exp_a); end
      if ({b_fd, b_dig, b_seg} !== exp_b) begin errors++; $display("FAIL random_b t=%0d got %h exp %h", m_t, {b_fd, b_dig, b_seg}, exp_b); end
      load = ($urandom % 6) == 0;
      ten_count = 4'($urandom);
      unit_count = 4'($urandom);
      reset = ($urandom % 150) == 0;
    end
    reset = 1'b0; load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_deferred();
    test_lz_range();
    test_gapless();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
